// File: rtl/mem_tester_pkg.sv
// Shared wires package: request/response records for the simple 32-bit memory bus.
package mem_tester_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
  } mem_out_type;

endpackage

// File: rtl/mem_tester_if.sv
// Memory bus bundle between the tester (master) and the memory responder (slave).
interface mem_tester_if;
  import mem_tester_pkg::*;

  mem_in_type  mem_in;
  mem_out_type mem_out;

  modport master (output mem_in, input mem_out);
  modport slave  (input mem_in, output mem_out);
endinterface

// File: rtl/mem_tester.sv
// Memory tester: writes a pattern, overwrites one byte lane per word, then reads back and counts errors.
//
// state | meaning
// IDLE  | waiting for start after reset
// WRITE | issue full-word write of p(i)
// BYTE  | issue single-lane write of the inverted lane byte
// READ  | issue read of word i
// WAIT  | request outstanding; ret records the phase to resume
// DONE  | run finished; done/pass/tmo/err_count held until next start
module mem_tester
  import mem_tester_pkg::*;
#(
  parameter logic [31:0] base_addr = 32'h0,
  parameter int          words     = 1024,
  parameter logic [31:0] seed      = 32'hA5A5A5A5,
  parameter int          timeout   = 4096
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  mem_tester_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         tmo,
  output logic [15:0]  err_count,
  output logic [31:0]  fail_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, BYTE, READ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {PH_WRITE, PH_BYTE, PH_READ} phase_t;

  localparam int CNT_W = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(timeout - 1);
  localparam logic [15:0] LAST = 16'(words - 1);

  typedef struct packed {
    state_t           state;
    phase_t           ret;
    logic [15:0]      idx;
    logic [CNT_W-1:0] cnt;
    mem_in_type       req;
    logic             done;
    logic             pass;
    logic             tmo;
    logic [15:0]      err_count;
    logic [31:0]      fail_addr;
  } reg_t;

  localparam reg_t R_RST = '0;

  reg_t r, rin;
  logic count_err;
  logic finish;

  function automatic logic [31:0] addr_of(input logic [15:0] idx);
    return base_addr + {14'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] pattern(input logic [15:0] idx);
    return addr_of(idx) ^ seed;
  endfunction

  function automatic logic [7:0] flip_byte(input logic [15:0] idx);
    logic [31:0] p;
    p = pattern(idx);
    return ~p[{idx[1:0], 3'b000} +: 8];
  endfunction

  // Word contents after the WRITE and BYTE phases have both landed.
  function automatic logic [31:0] expected(input logic [15:0] idx);
    logic [31:0] e;
    e = pattern(idx);
    e[{idx[1:0], 3'b000} +: 8] = flip_byte(idx);
    return e;
  endfunction

  function automatic mem_in_type make_req(input logic [31:0] addr, input logic [31:0] wdata,
                                          input logic [3:0] wstrb);
    mem_in_type q;
    q           = '0;
    q.mem_valid = 1'b1;
    q.mem_addr  = addr;
    q.mem_wdata = wdata;
    q.mem_wstrb = wstrb;
    return q;
  endfunction

  function automatic state_t phase_state(input phase_t ph);
    case (ph)
      PH_WRITE: return WRITE;
      PH_BYTE:  return BYTE;
      default:  return READ;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) r <= R_RST;
    else       r <= rin;
  end

  always_comb begin
    rin               = r;
    rin.req.mem_valid = 1'b0;
    count_err         = 1'b0;
    finish            = 1'b0;

    case (r.state)
      IDLE, DONE: begin
        if (start) begin
          rin.state     = WRITE;
          rin.idx       = '0;
          rin.err_count = '0;
          rin.fail_addr = '0;
          rin.pass      = 1'b0;
          rin.done      = 1'b0;
          rin.tmo       = 1'b0;
        end
      end
      WRITE: begin
        rin.req   = make_req(addr_of(r.idx), pattern(r.idx), 4'b1111);
        rin.ret   = PH_WRITE;
        rin.cnt   = CNT_LOAD;
        rin.state = WAIT;
      end
      BYTE: begin
        rin.req   = make_req(addr_of(r.idx), {4{flip_byte(r.idx)}}, 4'b0001 << r.idx[1:0]);
        rin.ret   = PH_BYTE;
        rin.cnt   = CNT_LOAD;
        rin.state = WAIT;
      end
      READ: begin
        rin.req   = make_req(addr_of(r.idx), 32'h0, 4'b0000);
        rin.ret   = PH_READ;
        rin.cnt   = CNT_LOAD;
        rin.state = WAIT;
      end
      WAIT: begin
        if (bus.mem_out.mem_ready) begin
          count_err = bus.mem_out.mem_error ||
                      ((r.ret == PH_READ) && (bus.mem_out.mem_rdata != expected(r.idx)));
          if (r.idx == LAST) begin
            rin.idx = '0;
            case (r.ret)
              PH_WRITE: rin.state = BYTE;
              PH_BYTE:  rin.state = READ;
              default:  finish    = 1'b1;
            endcase
          end else begin
            rin.idx   = r.idx + 16'd1;
            rin.state = phase_state(r.ret);
          end
        end else if (r.cnt == '0) begin
          rin.tmo   = 1'b1;
          count_err = 1'b1;
          finish    = 1'b1;
        end else begin
          rin.cnt = r.cnt - CNT_W'(1);
        end
      end
      default: rin = R_RST;
    endcase

    // A saturated counter is never zero again, so zero marks the first error of the run.
    if (count_err) begin
      if (r.err_count != 16'hFFFF) rin.err_count = r.err_count + 16'd1;
      if (r.err_count == '0)       rin.fail_addr = addr_of(r.idx);
    end

    if (finish) begin
      rin.state = DONE;
      rin.done  = 1'b1;
      rin.pass  = (rin.err_count == '0) && !rin.tmo;
    end
  end

  assign bus.mem_in = r.req;
  assign busy       = (r.state != IDLE) && (r.state != DONE);
  assign done       = r.done;
  assign pass       = r.pass;
  assign tmo        = r.tmo;
  assign err_count  = r.err_count;
  assign fail_addr  = r.fail_addr;

endmodule

// File: tb/tb_mem_tester.sv
// Bench for mem_tester: responder model with a request scoreboard, plus a words=1 instance.
module tb_mem_tester;
  import mem_tester_pkg::*;

  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] SEED  = 32'hA5A5A5A5;
  localparam int          WORDS = 4;
  localparam int          TMO   = 16;
  localparam logic [31:0] BASE1 = 32'h40;
  localparam logic [31:0] SEED1 = 32'h12345678;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic start  = 1'b0;
  logic start1 = 1'b0;
  logic busy, done, pass, tmo;
  logic [15:0] err_count;
  logic [31:0] fail_addr;
  logic busy1, done1, pass1, tmo1;
  logic [15:0] err_count1;
  logic [31:0] fail_addr1;

  mem_tester_if mif();
  mem_tester_if mif1();

  mem_tester #(.base_addr(BASE), .words(WORDS), .seed(SEED), .timeout(TMO)) u_dut (
    .clock(clock), .reset(reset), .start(start), .bus(mif),
    .busy(busy), .done(done), .pass(pass), .tmo(tmo),
    .err_count(err_count), .fail_addr(fail_addr)
  );

  mem_tester #(.base_addr(BASE1), .words(1), .seed(SEED1), .timeout(8)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .bus(mif1),
    .busy(busy1), .done(done1), .pass(pass1), .tmo(tmo1),
    .err_count(err_count1), .fail_addr(fail_addr1)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_wstrb[$];
  logic [31:0] mem [0:63];
  logic [31:0] rd_hold = '0;
  logic        prev_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_req_run = 0;
  int          req3_cyc = 0;
  int          drop_num = 0;
  int          pend = 0;
  int          widx;
  bit          corrupt = 1'b0;

  logic [31:0] mem1 = '0;
  logic [3:0]  log1_wstrb[$];
  logic [31:0] log1_wdata[$];
  int          n1_req = 0;
  bit          pend1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_addr(input int i);
    return BASE + 32'(4 * i);
  endfunction

  function automatic logic [31:0] m_pat(input int i);
    return m_addr(i) ^ SEED;
  endfunction

  function automatic logic [7:0] m_byte(input int i);
    logic [31:0] p;
    p = m_pat(i);
    return 8'(~(p >> (8 * (i % 4))));
  endfunction

  task automatic push_run();
    exp_q.delete();
    log_addr.delete();
    log_wdata.delete();
    log_wstrb.delete();
    n_req_run = 0;
    for (int i = 0; i < WORDS; i++) exp_q.push_back('{m_addr(i), m_pat(i), 4'b1111});
    for (int i = 0; i < WORDS; i++) exp_q.push_back('{m_addr(i), {4{m_byte(i)}}, 4'(1 << (i % 4))});
    for (int i = 0; i < WORDS; i++) exp_q.push_back('{m_addr(i), 32'h0, 4'b0000});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int at_cyc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge clock);
      k++;
    end
    at_cyc = cyc;
    chk("done_seen", done, 1);
  endtask

  task automatic wait_reqs(input int n, input int bound);
    int k;
    k = 0;
    while (n_req_run < n && k < bound) begin
      @(negedge clock);
      k++;
    end
    chk("req_progress", 32'(n_req_run), 32'(n));
  endtask

  task automatic check_outcome(input string t, input logic [15:0] e_err, input logic [31:0] e_fail,
                               input logic e_pass, input logic e_tmo);
    chk({t, "_err_count"}, err_count, e_err);
    chk({t, "_fail_addr"}, fail_addr, e_fail);
    chk({t, "_pass"}, pass, e_pass);
    chk({t, "_tmo"}, tmo, e_tmo);
    chk({t, "_busy"}, busy, 0);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_pass"}, pass, 0);
    chk({t, "_tmo"}, tmo, 0);
    chk({t, "_err_count"}, err_count, 0);
    chk({t, "_fail_addr"}, fail_addr, 0);
    chk({t, "_mem_in_zero"}, mif.mem_in == '0, 1);
  endtask

  // Responder for the main DUT: ready two cycles after each request, byte-strobed memory.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      mif.mem_out.mem_ready = 1'b0;
      if (pend == 1) begin
        mif.mem_out.mem_ready = 1'b1;
        mif.mem_out.mem_rdata = rd_hold;
        pend = 0;
      end else if (pend > 1) begin
        pend--;
      end
      if (mif.mem_in.mem_valid) begin
        n_req_run++;
        if (n_req_run == 3) req3_cyc = cyc;
        chk("valid_pulse", prev_valid, 0);
        chk("instr_zero", mif.mem_in.mem_instr, 0);
        log_addr.push_back(mif.mem_in.mem_addr);
        log_wdata.push_back(mif.mem_in.mem_wdata);
        log_wstrb.push_back(mif.mem_in.mem_wstrb);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", mif.mem_in.mem_valid, 0);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          chk("req_addr", mif.mem_in.mem_addr, e.addr);
          chk("req_wstrb", mif.mem_in.mem_wstrb, e.wstrb);
          if (e.wstrb != 4'b0000) chk("req_wdata", mif.mem_in.mem_wdata, e.wdata);
        end
        widx = int'(mif.mem_in.mem_addr[7:2]);
        for (int b = 0; b < 4; b++)
          if (mif.mem_in.mem_wstrb[b]) mem[widx][8*b +: 8] = mif.mem_in.mem_wdata[8*b +: 8];
        if (!(drop_num != 0 && n_req_run == drop_num)) begin
          rd_hold = mem[widx];
          if (corrupt && mif.mem_in.mem_addr == 32'h8) rd_hold[0] = ~rd_hold[0];
          pend = 2;
        end
      end
      prev_valid = mif.mem_in.mem_valid;
    end
  end

  // Responder for the words=1 DUT: ready one cycle after each request.
  initial begin
    forever begin
      @(negedge clock);
      mif1.mem_out.mem_ready = 1'b0;
      if (pend1) begin
        mif1.mem_out.mem_ready = 1'b1;
        mif1.mem_out.mem_rdata = mem1;
        pend1 = 1'b0;
      end
      if (mif1.mem_in.mem_valid) begin
        n1_req++;
        chk("w1_addr", mif1.mem_in.mem_addr, BASE1);
        log1_wstrb.push_back(mif1.mem_in.mem_wstrb);
        log1_wdata.push_back(mif1.mem_in.mem_wdata);
        for (int b = 0; b < 4; b++)
          if (mif1.mem_in.mem_wstrb[b]) mem1[8*b +: 8] = mif1.mem_in.mem_wdata[8*b +: 8];
        pend1 = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int dc;
    int nr;
    int k;
    mif.mem_out  = '0;
    mif1.mem_out = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_zero("reset");
    @(negedge clock);

    // Test 1: clean run on both instances
    push_run();
    start1 = 1'b1;
    pulse_start();
    start1 = 1'b0;
    wait_done(400, dc);
    check_outcome("t1", 16'd0, 32'h0, 1'b1, 1'b0);
    chk("t1_q_empty", 32'(exp_q.size()), 0);
    chk("t1_nreq", 32'(n_req_run), 12);
    chk("t1_w1_addr", log_addr[1], 32'h4);
    chk("t1_w1_wdata", log_wdata[1], 32'hA5A5A5A1);
    chk("t1_b1_wstrb", log_wstrb[5], 4'b0010);
    chk("t1_b1_wdata", log_wdata[5], 32'h5A5A5A5A);
    chk("t1_r1_wstrb", log_wstrb[9], 4'b0000);
    chk("t1_r1_e", mem[1], 32'hA5A55AA1);
    k = 0;
    while (done1 !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("w1_done", done1, 1);
    chk("w1_pass", pass1, 1);
    chk("w1_err", err_count1, 0);
    chk("w1_nreq", 32'(n1_req), 3);
    chk("w1_strb_write", log1_wstrb[0], 4'b1111);
    chk("w1_strb_byte", log1_wstrb[1], 4'b0001);
    chk("w1_strb_read", log1_wstrb[2], 4'b0000);
    chk("w1_byte_wdata", log1_wdata[1], 32'hC7C7C7C7);
    chk("w1_mem", mem1, 32'h123456C7);

    // Test 2: corrupted read at address 8
    corrupt = 1'b1;
    push_run();
    pulse_start();
    wait_done(400, dc);
    check_outcome("t2", 16'd1, 32'h8, 1'b0, 1'b0);
    chk("t2_q_empty", 32'(exp_q.size()), 0);
    corrupt = 1'b0;

    // Test 3: third request never answered
    drop_num = 3;
    push_run();
    pulse_start();
    wait_done(400, dc);
    check_outcome("t3", 16'd1, 32'h8, 1'b0, 1'b1);
    chk("t3_q_left", 32'(exp_q.size()), 9);
    chk("t3_latency_ok", (dc - req3_cyc) <= 20, 1);
    drop_num = 0;

    // Test 4: reset during BYTE-WAIT, late ready follows
    push_run();
    pulse_start();
    wait_reqs(5, 200);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    check_zero("t4");
    nr = n_req_run;
    repeat (12) @(negedge clock);
    check_zero("t4_late");
    chk("t4_no_req", 32'(n_req_run), 32'(nr));

    // Test 5: starts while busy are ignored; back-to-back start in DONE repeats the run
    push_run();
    pulse_start();
    wait_reqs(3, 200);
    pulse_start();
    wait_reqs(7, 200);
    pulse_start();
    wait_done(400, dc);
    check_outcome("t5a", 16'd0, 32'h0, 1'b1, 1'b0);
    chk("t5a_nreq", 32'(n_req_run), 12);
    chk("t5a_q_empty", 32'(exp_q.size()), 0);
    push_run();
    pulse_start();
    chk("t5b_busy_again", busy, 1);
    wait_done(400, dc);
    check_outcome("t5b", 16'd0, 32'h0, 1'b1, 1'b0);
    chk("t5b_nreq", 32'(n_req_run), 12);
    chk("t5b_q_empty", 32'(exp_q.size()), 0);

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_tester.md
MEM_TESTER -- requirements
Module: mem_tester

Interface
REQ-001 The block SHALL have parameter base_addr, default 32'h0, meaning the byte address of the first tested word (bits [1:0] are 0).
REQ-002 The block SHALL have parameter words, default 1024, meaning the number of 32-bit words tested (1..65535).
REQ-003 The block SHALL have parameter seed, default 32'hA5A5A5A5, meaning the XOR value for the test pattern.
REQ-004 The block SHALL have parameter timeout, default 4096, meaning the maximum cycles it waits for mem_ready.
REQ-005 Ports SHALL be: clock in 1, single clock; reset in 1, synchronous, active-high.
REQ-006 Port start SHALL be in, 1 bit: a one-cycle pulse that begins a test run.
REQ-007 Port mem_out SHALL be in, mem_out_type: the responder's mem_rdata, mem_ready and mem_error.
REQ-008 Port mem_in SHALL be out, mem_in_type: mem_valid, mem_addr, mem_wdata and mem_wstrb; all other fields SHALL be 0.
REQ-009 Ports busy, done, pass and tmo SHALL each be out, 1 bit.
REQ-010 Port err_count SHALL be out, 16 bits.
REQ-011 Port fail_addr SHALL be out, 32 bits.

Function
REQ-012 Word i SHALL be at address a(i) = base_addr + 4*i, and its pattern SHALL be p(i) = a(i) ^ seed.
REQ-013 The FSM SHALL have states IDLE, WRITE, BYTE, READ, WAIT and DONE; WAIT SHALL record which phase it returns to.
REQ-014 In IDLE, start=1 SHALL clear err_count, fail_addr, pass, done and tmo, set i=0, and enter WRITE on the next cycle.
REQ-015 start SHALL be ignored in every state except IDLE and DONE.
REQ-016 A WRITE request SHALL use mem_wstrb=4'b1111 and mem_wdata=p(i).
REQ-017 A BYTE request SHALL use lane = i[1:0] and mem_wstrb = 1<<lane.
REQ-018 A BYTE request's mem_wdata SHALL be byte b = ~p(i)[8*lane+7:8*lane], replicated in all four lanes.
REQ-019 A READ request SHALL use mem_wstrb=0.
REQ-020 The expected read value e(i) SHALL be p(i) with the lane byte replaced by b.
REQ-021 For every request, mem_valid SHALL be high for exactly one cycle.
REQ-022 mem_addr, mem_wdata and mem_wstrb SHALL be registered and held stable until mem_ready is seen.
REQ-023 The block SHALL then enter WAIT.
REQ-024 In WAIT, when mem_ready=1, the next request SHALL be issued no earlier than the following cycle.
REQ-025 Each phase SHALL step i through 0..words-1 and then pass to the next phase with i=0, in the order WRITE, BYTE, READ, DONE.
REQ-026 A read completes when mem_ready=1 in READ-WAIT; it SHALL be an error if mem_rdata != e(i) or mem_error=1.
REQ-027 A write completes when mem_ready=1; it SHALL be an error if mem_error=1.
REQ-028 On each error, err_count SHALL increment, saturating at 16'hFFFF.
REQ-029 On the first error of a run, fail_addr SHALL take a(i).
REQ-030 A WAIT counter SHALL reset on each request.
REQ-031 If the WAIT counter reaches timeout without mem_ready, the block SHALL set tmo=1, count one error and go to DONE.
REQ-032 On the first timeout error of a run, fail_addr SHALL take a(i).
REQ-033 A mem_ready that is not in WAIT SHALL be ignored.
REQ-034 busy SHALL be 1 in all states except IDLE and DONE.
REQ-035 In DONE, done=1 and pass = (err_count==0 && tmo==0); both SHALL stay sticky until the next start.
REQ-036 start in DONE SHALL behave as in IDLE.
REQ-037 When words=1, each phase SHALL issue exactly one request.

Reset
REQ-038 reset=1 SHALL force state IDLE, i=0, mem_valid=0 and all mem_in fields to 0.
REQ-039 reset=1 SHALL force busy=0, done=0, pass=0, tmo=0, err_count=0 and fail_addr=0 on the next clock edge, including mid-transaction.
REQ-040 A mem_ready that arrives after a mid-transaction reset SHALL be ignored.

Structure
REQ-041 mem_in_type and mem_out_type SHALL come from the shared wires package.
REQ-042 The state enumeration and the phase-return field SHALL be local typedefs, kept in the module's register record.
REQ-043 No new package constants SHALL be added.
REQ-044 No sub-module SHALL be used; p(i) and e(i) SHALL be local functions.

Verification
REQ-045 Test 1: words=4, base=0, seed=A5A5A5A5, with an ideal 2-cycle responder, then a start pulse -> 12 requests, and on WRITE word 1 addr=4, wdata=A5A5A5A1.
REQ-046 Test 1 (cont.): on BYTE word 1, strobe=0010 and wdata=5A5A5A5A; on READ word 1, e=A5A55AA1 -> done=1, pass=1, err_count=0.
REQ-047 Test 2: the responder corrupts read bit 0 at address 8 -> err_count=1, fail_addr=8, pass=0.
REQ-048 Test 3: the responder never asserts ready on the third request, with timeout=16 -> tmo=1, err_count=1, fail_addr=8, done=1 within 20 cycles of that request.
REQ-049 Test 4: reset is pulsed during BYTE-WAIT and a late mem_ready follows -> all outputs are 0, state is IDLE, and no new request is issued until start.
REQ-050 Test 5: start pulses while busy, plus a back-to-back start in DONE -> the first are ignored and the second run repeats identical results; mem_valid is never high two consecutive cycles.
